// File: rtl/vga_axil_regs.sv
// vga_axil_regs: AXI4-Lite slave register file exposing NUM_REGS words to the VGA control logic.
// Define VGA_AXIL_REGS_STRB_EN to honour wstrb byte lanes; otherwise every legal write updates the full word.
module vga_axil_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int OFF = (DATA_W == 64) ? 3 : 2;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
  localparam logic [ADDR_W-1:0] NUM_A = ADDR_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return ((a & OFF_MASK) == '0) && ((a >> OFF) < NUM_A);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  logic [DATA_W-1:0] reg_file_q [NUM_REGS];
  logic [DATA_W-1:0] reg_file_d [NUM_REGS];

  logic              aw_hold_q, aw_hold_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_hold_q, w_hold_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_legal, rd_legal;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

`ifdef VGA_AXIL_REGS_STRB_EN
  logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
  logic [DATA_W/8-1:0] wr_strb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
`endif

  // Ready signals are forced low while reset is asserted.
  assign awready = !arst && !aw_hold_q && !bvalid_q;
  assign wready  = !arst && !w_hold_q && !bvalid_q;
  assign arready = !arst && !rvalid_q;

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_q[i*DATA_W +: DATA_W] = reg_file_q[i];
    end
  end

  // A held AW/W beat takes priority over the live channel when forming the commit.
  always_comb begin
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    wr_addr  = aw_hold_q ? aw_addr_q : awaddr;
    wr_data  = w_hold_q ? w_data_q : wdata;
`ifdef VGA_AXIL_REGS_STRB_EN
    wr_strb  = w_hold_q ? w_strb_q : wstrb;
`endif
    commit   = (aw_hold_q || aw_hs) && (w_hold_q || w_hs) && !bvalid_q;
    wr_legal = is_legal(wr_addr);
    wr_idx   = to_idx(wr_addr);
  end

  always_comb begin
    aw_hold_d = aw_hold_q;
    aw_addr_d = aw_addr_q;
    w_hold_d  = w_hold_q;
    w_data_d  = w_data_q;
`ifdef VGA_AXIL_REGS_STRB_EN
    w_strb_d  = w_strb_q;
`endif
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_legal ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_hold_d = 1'b1;
        aw_addr_d = awaddr;
      end
      if (w_hs) begin
        w_hold_d = 1'b1;
        w_data_d = wdata;
`ifdef VGA_AXIL_REGS_STRB_EN
        w_strb_d = wstrb;
`endif
      end
      if (bvalid_q && bready) begin
        bvalid_d = 1'b0;
      end
    end
  end

  always_comb begin
    reg_file_d = reg_file_q;
    wr_pulse_d = '0;
    if (commit && wr_legal) begin
      wr_pulse_d[wr_idx] = 1'b1;
`ifdef VGA_AXIL_REGS_STRB_EN
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_strb[b]) begin
          reg_file_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
`else
      reg_file_d[wr_idx] = wr_data;
`endif
    end
  end

  // Reads sample the pre-commit register contents, so a same-edge write is not visible.
  always_comb begin
    ar_hs    = arvalid && arready;
    rd_legal = is_legal(araddr);
    rd_idx   = to_idx(araddr);
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_legal ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_legal ? reg_file_q[rd_idx] : '0;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file_q[i] <= RESET_VAL;
      end
      aw_hold_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_hold_q   <= 1'b0;
      w_data_q   <= '0;
`ifdef VGA_AXIL_REGS_STRB_EN
      w_strb_q   <= '0;
`endif
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      reg_file_q <= reg_file_d;
      aw_hold_q  <= aw_hold_d;
      aw_addr_q  <= aw_addr_d;
      w_hold_q   <= w_hold_d;
      w_data_q   <= w_data_d;
`ifdef VGA_AXIL_REGS_STRB_EN
      w_strb_q   <= w_strb_d;
`endif
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
